// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
//   Owns the PC and issues word fetches on a req/gnt/rvalid instruction bus.
//   Returned words are buffered in a small queue and presented one per cycle
//   to the if_id register. Redirects from ex and stalls from ctrl are applied
//   here. Responses still in flight for a squashed stream are discarded.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hold_flag_i [2:0]        stall request from ctrl (any nonzero value stalls)
//   jump_flag_i, jump_addr_i redirect request and target (bits [1:0] ignored)
//   ibus_req_o, ibus_addr_o  fetch request and word address
//   ibus_gnt_i               request accepted this cycle
//   ibus_rvalid_i/rdata_i    in-order read response
//   ins_o, ins_addr_o        instruction and its address (NOP / 0 when idle)
//   ins_valid_o              queue head presented and consumed this cycle
module ifu_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_addr_o,
  output logic        ins_valid_o
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  outst_q, outst_d;
  logic [2:0]  drop_q, drop_d;
  logic [1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic        pend_q, pend_d;

  // Storage is sized for the largest DEPTH; only DEPTH entries are addressed.
  logic [31:0] qdata_q [4];
  logic [31:0] qaddr_q [4];
  logic [31:0] tag_q   [4];

  logic stall, credit, req, hs, rv_ok, push, pop;
  logic unused_jaddr;

  assign unused_jaddr = ^jump_addr_i[1:0];

  assign stall  = (hold_flag_i != 3'd0);
  assign credit = ({1'b0, count_q} + {1'b0, outst_q}) < {1'b0, DEPTH_C};
  // A request left pending without gnt is held even if a stall arrives;
  // only a redirect or reset may withdraw it.
  assign req    = !rst && !jump_flag_i && (pend_q || (credit && !stall));
  assign hs     = req && ibus_gnt_i;
  assign rv_ok  = ibus_rvalid_i && (outst_q != 3'd0);
  assign push   = rv_ok && (drop_q == 3'd0) && !jump_flag_i && !rst;
  assign pop    = !rst && !jump_flag_i && !stall && (count_q != 3'd0);

  assign ibus_req_o  = req;
  assign ibus_addr_o = pc_q;
  assign ins_valid_o = pop;
  assign ins_o       = pop ? qdata_q[rd_q] : NOP;
  assign ins_addr_o  = pop ? qaddr_q[rd_q] : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    outst_d  = outst_q + 3'(hs) - 3'(rv_ok);
    drop_d   = drop_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    tag_wr_d = hs ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = rv_ok ? ptr_inc(tag_rd_q) : tag_rd_q;
    pend_d   = req && !ibus_gnt_i;

    if (jump_flag_i) begin
      pc_d    = {jump_addr_i[31:2], 2'b00};
      count_d = 3'd0;
      rd_d    = 2'd0;
      wr_d    = 2'd0;
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_d  = outst_d;
    end else begin
      if (hs) pc_d = pc_q + 32'd4;
      if (rv_ok && (drop_q != 3'd0)) drop_d = drop_q - 3'd1;
      count_d = count_q + 3'(push) - 3'(pop);
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_ADDR;
      count_q  <= 3'd0;
      outst_q  <= 3'd0;
      drop_q   <= 3'd0;
      rd_q     <= 2'd0;
      wr_q     <= 2'd0;
      tag_rd_q <= 2'd0;
      tag_wr_q <= 2'd0;
      pend_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
      pend_q   <= pend_d;
      assert (!(push && !pop && (count_q == DEPTH_C)));
    end
  end

  // Data storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (hs) tag_q[tag_wr_q] <= pc_q;
    if (push) begin
      qdata_q[wr_q] <= ibus_rdata_i;
      qaddr_q[wr_q] <= tag_q[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hold_flag_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] ins_o;
  logic [31:0] ins_addr_o;
  logic        ins_valid_o;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_ADDR(32'h0000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .hold_flag_i   (hold_flag_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .ins_o         (ins_o),
    .ins_addr_o    (ins_addr_o),
    .ins_valid_o   (ins_valid_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: instruction word derived from its address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  typedef struct packed {
    logic [2:0]  hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdaddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_iaddr;
  } vec_t;

  function automatic vec_t mkv(input int hold, input int jump, input int jaddr,
                               input int gnt, input int rv, input int rdaddr,
                               input int e_req, input int e_addr, input int e_vld,
                               input int e_iaddr);
    vec_t v;
    v.hold    = 3'(hold);
    v.jump    = 1'(jump);
    v.jaddr   = 32'(jaddr);
    v.gnt     = 1'(gnt);
    v.rv      = 1'(rv);
    v.rdaddr  = 32'(rdaddr);
    v.e_req   = 1'(e_req);
    v.e_addr  = 32'(e_addr);
    v.e_vld   = 1'(e_vld);
    v.e_iaddr = 32'(e_iaddr);
    return v;
  endfunction

  task automatic idle_inputs();
    hold_flag_i   = 3'd0;
    jump_flag_i   = 1'b0;
    jump_addr_i   = 32'h0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;
  endtask

  // Two reset edges; outputs are checked between them while rst is still high.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_req"},     32'(ibus_req_o),  32'h0);
    chk({tag, "_addr"},    ibus_addr_o,      32'h0);
    chk({tag, "_vld"},     32'(ins_valid_o), 32'h0);
    chk({tag, "_ins"},     ins_o,            NOP);
    chk({tag, "_insaddr"}, ins_addr_o,       32'h0);
    @(posedge clk);
  endtask

  localparam int NV = 19;
  vec_t vt [NV];

  logic [31:0] bq_addr [$];
  int          bq_rdy  [$];
  logic [31:0] exp_pc;
  logic        prev_pend;
  logic [31:0] prev_addr;
  int          presented;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // hold, jump, jaddr, gnt, rv, rdaddr | req, addr, vld, ins_addr
    vt[0]  = mkv(0, 0, 0,     1, 0, 0,      1, 'h0,   0, 0);
    vt[1]  = mkv(0, 0, 0,     1, 1, 'h0,    1, 'h4,   0, 0);
    vt[2]  = mkv(0, 0, 0,     1, 1, 'h4,    0, 'h8,   1, 'h0);
    vt[3]  = mkv(0, 0, 0,     1, 0, 0,      1, 'h8,   1, 'h4);
    vt[4]  = mkv(0, 0, 0,     1, 1, 'h8,    1, 'hC,   0, 0);
    vt[5]  = mkv(1, 0, 0,     1, 1, 'hC,    0, 'h10,  0, 0);
    vt[6]  = mkv(1, 0, 0,     1, 0, 0,      0, 'h10,  0, 0);
    vt[7]  = mkv(3, 0, 0,     1, 0, 0,      0, 'h10,  0, 0);
    vt[8]  = mkv(0, 0, 0,     1, 0, 0,      0, 'h10,  1, 'h8);
    vt[9]  = mkv(0, 0, 0,     1, 0, 0,      1, 'h10,  1, 'hC);
    vt[10] = mkv(0, 0, 0,     1, 0, 0,      1, 'h14,  0, 0);
    vt[11] = mkv(0, 1, 'h103, 1, 1, 'h10,   0, 'h18,  0, 0);
    vt[12] = mkv(0, 0, 0,     0, 1, 'h14,   1, 'h100, 0, 0);
    vt[13] = mkv(1, 0, 0,     0, 0, 0,      1, 'h100, 0, 0);
    vt[14] = mkv(0, 0, 0,     1, 0, 0,      1, 'h100, 0, 0);
    vt[15] = mkv(0, 0, 0,     0, 1, 'h100,  1, 'h104, 0, 0);
    vt[16] = mkv(0, 0, 0,     1, 0, 0,      1, 'h104, 1, 'h100);
    vt[17] = mkv(0, 0, 0,     0, 1, 'h104,  1, 'h108, 0, 0);
    vt[18] = mkv(0, 0, 0,     0, 0, 0,      1, 'h108, 1, 'h104);

    // Reset state, then the directed vector table.
    do_reset("rst0");
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst           = 1'b0;
      hold_flag_i   = vt[i].hold;
      jump_flag_i   = vt[i].jump;
      jump_addr_i   = vt[i].jaddr;
      ibus_gnt_i    = vt[i].gnt;
      ibus_rvalid_i = vt[i].rv;
      ibus_rdata_i  = vt[i].rv ? memw(vt[i].rdaddr) : 32'h0;
      #1;
      chk($sformatf("v%0d_req", i),     32'(ibus_req_o),  32'(vt[i].e_req));
      chk($sformatf("v%0d_addr", i),    ibus_addr_o,      vt[i].e_addr);
      chk($sformatf("v%0d_vld", i),     32'(ins_valid_o), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_insaddr", i), ins_addr_o,       vt[i].e_iaddr);
      chk($sformatf("v%0d_ins", i),     ins_o,
          vt[i].e_vld ? memw(vt[i].e_iaddr) : NOP);
    end

    // Gnt withheld 5 cycles (with a hold in the middle): request stays put,
    // then a jump withdraws it and the target is requested the next cycle.
    do_reset("rst1");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      hold_flag_i = (k == 2) ? 3'd2 : 3'd0;
      #1;
      chk($sformatf("stall%0d_req", k),  32'(ibus_req_o), 32'h1);
      chk($sformatf("stall%0d_addr", k), ibus_addr_o,     32'h0);
    end
    @(negedge clk);
    idle_inputs();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0203;
    #1;
    chk("stalljmp_req", 32'(ibus_req_o), 32'h0);
    @(negedge clk);
    idle_inputs();
    ibus_gnt_i = 1'b1;
    #1;
    chk("redir_req",  32'(ibus_req_o),  32'h1);
    chk("redir_addr", ibus_addr_o,      32'h200);
    chk("redir_vld",  32'(ins_valid_o), 32'h0);
    @(negedge clk);
    idle_inputs();
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = memw(32'h200);
    #1;
    chk("redir_next_addr", ibus_addr_o, 32'h204);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("redir_out_vld",  32'(ins_valid_o), 32'h1);
    chk("redir_out_addr", ins_addr_o,       32'h200);
    chk("redir_out_ins",  ins_o,            memw(32'h200));

    // Random bus delays, holds and jumps against a reference PC model.
    do_reset("rst2");
    bq_addr.delete();
    bq_rdy.delete();
    exp_pc    = 32'h0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    presented = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      jump_flag_i = ($urandom_range(0, 39) == 0);
      jump_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom_range(0, 4095));
      hold_flag_i = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if (bq_addr.size() > 0 && bq_rdy[0] <= cyc) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = memw(bq_addr[0]);
      end
      ibus_gnt_i = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_pend && !jump_flag_i) begin
        chk("rnd_req_stable",  32'(ibus_req_o), 32'h1);
        chk("rnd_addr_stable", ibus_addr_o,     prev_addr);
      end
      if (jump_flag_i) chk("rnd_jump_vld", 32'(ins_valid_o), 32'h0);
      if (ins_valid_o) begin
        chk("rnd_insaddr", ins_addr_o, exp_pc);
        chk("rnd_ins",     ins_o,      memw(exp_pc));
        exp_pc = exp_pc + 32'd4;
        presented++;
      end
      if (jump_flag_i) exp_pc = {jump_addr_i[31:2], 2'b00};
      if (ibus_rvalid_i) begin
        void'(bq_addr.pop_front());
        void'(bq_rdy.pop_front());
      end
      if (ibus_req_o && ibus_gnt_i) begin
        bq_addr.push_back(ibus_addr_o);
        bq_rdy.push_back(cyc + 1 + int'($urandom_range(0, 3)));
      end
      prev_pend = ibus_req_o && !ibus_gnt_i;
      prev_addr = ibus_addr_o;
    end
    chk("rnd_progress", 32'(presented > 1000), 32'h1);

    // Reset mid-stream with requests in flight; the bus model is reset too.
    do_reset("rst3");
    bq_addr.delete();
    bq_rdy.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("restart_req",  32'(ibus_req_o),  32'h1);
    chk("restart_addr", ibus_addr_o,      32'h0);
    chk("restart_vld",  32'(ins_valid_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
